// File: rtl/s_axis_cc_adapt_gen.sv
// s_axis_cc_adapt_gen: adapts LitePCIe TLP-format completions to the
// UltraScale+ s_axis_cc descriptor interface. The 3-DW TLP header on the first
// beat of each completion is rewritten into the 3-DW CC descriptor. An elastic
// buffer feeds a single registered output stage.
// Optional feature macro: LITEPCIE_CC_PARITY_EN (odd byte parity on tuser_a).
module s_axis_cc_adapt_gen #(
   parameter int unsigned DATA_WIDTH    = 512,
   parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
   parameter int unsigned DW_KEEP_WIDTH = DATA_WIDTH / 32,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                     user_clk,
   input  logic                     user_reset,
   input  logic [DATA_WIDTH-1:0]    s_axis_cc_tdata,
   input  logic [KEEP_WIDTH-1:0]    s_axis_cc_tkeep,
   input  logic                     s_axis_cc_tlast,
   input  logic [3:0]               s_axis_cc_tuser,
   input  logic                     s_axis_cc_tvalid,
   output logic                     s_axis_cc_tready,
   output logic [DATA_WIDTH-1:0]    s_axis_cc_tdata_a,
   output logic [DW_KEEP_WIDTH-1:0] s_axis_cc_tkeep_a,
   output logic                     s_axis_cc_tlast_a,
   output logic [KEEP_WIDTH:0]      s_axis_cc_tuser_a,
   output logic                     s_axis_cc_tvalid_a,
   input  logic [3:0]               s_axis_cc_tready_a
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned ENT_W  = DATA_WIDTH + DW_KEEP_WIDTH + 3;
   localparam int unsigned LAST_B = DATA_WIDTH;
   localparam int unsigned KEEP_B = DATA_WIDTH + 1;
   localparam int unsigned ECRC_B = DATA_WIDTH + 1 + DW_KEEP_WIDTH;
   localparam int unsigned DISC_B = ECRC_B + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic {
      ST_FIRST = 1'b0,
      ST_BODY  = 1'b1
   } state_e;

   // buffer storage and control
   logic [ENT_W-1:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     ready_q, ready_d;
   state_e                   state_q, state_d;

   // output stage
   logic                     out_valid_q, out_valid_d;
   logic                     out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
   logic [DW_KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
   logic [KEEP_WIDTH:0]      out_user_q, out_user_d;

   // datapath / handshake helpers
   logic [DW_KEEP_WIDTH-1:0] in_dwkeep;
   logic [ENT_W-1:0]         in_ent;
   logic [ENT_W-1:0]         src_ent;
   logic [DATA_WIDTH-1:0]    src_data;
   logic [DATA_WIDTH-1:0]    ld_data;
   logic [KEEP_WIDTH-1:0]    ld_par;
   logic                     fifo_empty;
   logic                     in_fire;
   logic                     pop_out;
   logic                     load_en;
   logic                     take;
   logic                     fifo_push;
   logic                     fifo_pop;
   logic                     unused_c;

   // ready bits [3:1], tuser[2:1] and non-leading byte keeps carry no meaning here
   assign unused_c = ^{s_axis_cc_tready_a[3:1], s_axis_cc_tuser[2:1], s_axis_cc_tkeep};

   // dword keep is the keep of the first byte of each dword
   always_comb begin
      in_dwkeep = '0;
      for (int i = 0; i < int'(DW_KEEP_WIDTH); i++) begin
         in_dwkeep[i] = s_axis_cc_tkeep[4*i];
      end
   end

   assign in_ent = {s_axis_cc_tuser[3], s_axis_cc_tuser[0], in_dwkeep,
                    s_axis_cc_tlast, s_axis_cc_tdata};

   // handshake: the output register takes the buffer head, or the input beat directly when the buffer is empty
   always_comb begin
      fifo_empty = (cnt_q == '0);
      in_fire    = s_axis_cc_tvalid & ready_q;
      pop_out    = out_valid_q & s_axis_cc_tready_a[0];
      load_en    = ~out_valid_q | pop_out;
      take       = load_en & (~fifo_empty | in_fire);
      fifo_pop   = take & ~fifo_empty;
      fifo_push  = in_fire & ~(take & fifo_empty);
      src_ent    = fifo_empty ? in_ent : mem_q[rd_ptr_q];
   end

   // pointer and occupancy next-state; push and pop together leave occupancy unchanged
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (fifo_push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (fifo_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      ready_d = (cnt_d != CNT_FULL);
   end

   // beat-state FSM next-state: advances on every beat popped by the hard IP
   always_comb begin
      state_d = state_q;
      if (pop_out) begin
         state_d = out_last_q ? ST_FIRST : ST_BODY;
      end
   end

   // header rewrite for the beat being loaded; its position follows the post-pop FSM state
   always_comb begin
      src_data = src_ent[DATA_WIDTH-1:0];
      ld_data  = src_data;
      if (state_d == ST_FIRST) begin
         ld_data[95:0]  = '0;
         ld_data[6:0]   = src_data[70:64];
         ld_data[9:8]   = 2'b00;
         ld_data[28:16] = {1'b0, src_data[43:32]};
         ld_data[29]    = (src_data[29:24] == 6'b001011);
         ld_data[42:32] = {1'b0, src_data[9:0]};
         ld_data[45:43] = src_data[47:45];
         ld_data[46]    = src_data[14];
         ld_data[63:48] = src_data[95:80];
         ld_data[71:64] = src_data[79:72];
         ld_data[87:72] = src_data[63:48];
         ld_data[88]    = 1'b0;
         ld_data[91:89] = src_data[22:20];
         ld_data[94:92] = {1'b0, src_data[13:12]};
         ld_data[95]    = src_data[15] | src_ent[ECRC_B];
      end
   end

`ifdef LITEPCIE_CC_PARITY_EN
   // odd parity per output byte, taken from the rewritten data
   always_comb begin
      ld_par = '0;
      for (int k = 0; k < int'(KEEP_WIDTH); k++) begin
         ld_par[k] = ~^ld_data[8*k +: 8];
      end
   end
`else
   // parity generation disabled
   always_comb begin
      ld_par = '0;
   end
`endif

   // output register next-state: hold while stalled, reload on empty or pop
   always_comb begin
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_user_d  = out_user_q;
      if (take) begin
         out_valid_d = 1'b1;
         out_last_d  = src_ent[LAST_B];
         out_data_d  = ld_data;
         out_keep_d  = src_ent[KEEP_B +: DW_KEEP_WIDTH];
         out_user_d  = {ld_par, src_ent[DISC_B]};
      end else if (pop_out) begin
         out_valid_d = 1'b0;
      end
   end

   // buffer storage write; contents need no reset since occupancy gates reads
   always_ff @(posedge user_clk) begin
      if (fifo_push) begin
         mem_q[wr_ptr_q] <= in_ent;
      end
   end

   // FSM state register
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state_q <= ST_FIRST;
      end else begin
         state_q <= state_d;
      end
   end

   // control and output registers
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         ready_q     <= 1'b1;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_user_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_user_q  <= out_user_d;
      end
   end

   assign s_axis_cc_tready   = ready_q;
   assign s_axis_cc_tvalid_a = out_valid_q;
   assign s_axis_cc_tlast_a  = out_last_q;
   assign s_axis_cc_tdata_a  = out_data_q;
   assign s_axis_cc_tkeep_a  = out_keep_q;
   assign s_axis_cc_tuser_a  = out_user_q;

endmodule

// File: tb/tb_s_axis_cc_adapt_gen.sv
// Bench for s_axis_cc_adapt_gen (128-bit datapath, 4-entry buffer).
// A packet-level reference model predicts every output beat.
module tb_s_axis_cc_adapt_gen;

   localparam int unsigned DW  = 128;
   localparam int unsigned KW  = DW / 8;
   localparam int unsigned DKW = DW / 32;
`ifdef LITEPCIE_CC_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst;
   logic [DW-1:0]  in_data;
   logic [KW-1:0]  in_keep;
   logic           in_last;
   logic [3:0]     in_user;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  out_data;
   logic [DKW-1:0] out_keep;
   logic           out_last;
   logic [KW:0]    out_user;
   logic           out_valid;
   logic [3:0]     out_ready;

   always #5 clk = ~clk;

   s_axis_cc_adapt_gen #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (4)
   ) dut (
      .user_clk           (clk),
      .user_reset         (rst),
      .s_axis_cc_tdata    (in_data),
      .s_axis_cc_tkeep    (in_keep),
      .s_axis_cc_tlast    (in_last),
      .s_axis_cc_tuser    (in_user),
      .s_axis_cc_tvalid   (in_valid),
      .s_axis_cc_tready   (in_ready),
      .s_axis_cc_tdata_a  (out_data),
      .s_axis_cc_tkeep_a  (out_keep),
      .s_axis_cc_tlast_a  (out_last),
      .s_axis_cc_tuser_a  (out_user),
      .s_axis_cc_tvalid_a (out_valid),
      .s_axis_cc_tready_a (out_ready)
   );

   typedef struct packed {
      logic [DW-1:0]  data;
      logic [DKW-1:0] keep;
      logic           last;
      logic [KW:0]    user;
   } beat_t;

   beat_t exp_q[$];
   bit    mdl_first;
   bit    acc_flag;
   int    n_chk;
   int    n_bad;

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // CC descriptor assembled dword by dword from the TLP header fields
   function automatic logic [95:0] cc_desc(input logic [DW-1:0] h, input logic ecrc);
      logic [31:0] d0, d1, d2;
      logic        lk;
      lk = (h[29:24] == 6'b001011);
      d0 = {2'b00, lk, 1'b0, h[43:32], 6'd0, 2'b00, 1'b0, h[70:64]};
      d1 = {h[95:80], 1'b0, h[14], h[47:45], 1'b0, h[9:0]};
      d2 = {h[15] | ecrc, 1'b0, h[13:12], h[22:20], 1'b0, h[63:48], h[79:72]};
      return {d2, d1, d0};
   endfunction

   function automatic logic [KW-1:0] exp_par(input logic [DW-1:0] d);
      logic [KW-1:0] p;
      p = '0;
      for (int k = 0; k < int'(KW); k++) p[k] = ~^d[8*k +: 8];
      return PAR_EN ? p : '0;
   endfunction

   task automatic model_push();
      beat_t b;
      b.data = in_data;
      if (mdl_first) b.data[95:0] = cc_desc(in_data, in_user[0]);
      for (int i = 0; i < int'(DKW); i++) b.keep[i] = in_keep[4*i];
      b.last = in_last;
      b.user = {exp_par(b.data), in_user[3]};
      exp_q.push_back(b);
      mdl_first = in_last;
   endtask

   // one clock cycle, entered and left at a falling edge
   task automatic step();
      beat_t          e;
      bit             hold;
      logic [DW-1:0]  h_data;
      logic [DW-1:0]  h_ctl;
      acc_flag = in_valid & in_ready;
      if (out_valid & out_ready[0]) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_bad++;
            $display("FAIL unexpected_beat got=%0h exp=none", out_data);
         end else begin
            e = exp_q.pop_front();
            check_val("pop_data", out_data, e.data);
            check_val("pop_ctl", DW'({out_keep, out_last, out_user}), DW'({e.keep, e.last, e.user}));
         end
      end
      if (acc_flag) model_push();
      hold   = out_valid & ~out_ready[0];
      h_data = out_data;
      h_ctl  = DW'({out_valid, out_keep, out_last, out_user});
      @(negedge clk);
      if (hold) begin
         check_val("hold_data", out_data, h_data);
         check_val("hold_ctl", DW'({out_valid, out_keep, out_last, out_user}), h_ctl);
      end
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic [3:0] u);
      in_data  = d;
      in_keep  = k;
      in_last  = l;
      in_user  = u;
      in_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         step();
         if (acc_flag) break;
      end
      in_valid = 1'b0;
      check_val("send_accept", DW'(acc_flag), DW'(1'b1));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) step();
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 4'hF;
      for (int t = 0; t < 100; t++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         step();
      end
      check_val("drain_left", DW'(exp_q.size()), DW'(0));
      check_val("drain_valid", DW'(out_valid), DW'(1'b0));
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      exp_q.delete();
      mdl_first = 1'b1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] hdr;
      int            acc_cnt;
      bit            have;
      int            left;
      n_chk     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_keep   = '0;
      in_last   = 1'b0;
      in_user   = 4'h0;
      out_ready = 4'hF;
      mdl_first = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset values
      check_val("rst_tready", DW'(in_ready), DW'(1'b1));
      check_val("rst_tvalid_a", DW'(out_valid), DW'(1'b0));
      check_val("rst_tlast_a", DW'(out_last), DW'(1'b0));
      check_val("rst_tdata_a", out_data, '0);
      check_val("rst_tkeep_a", DW'(out_keep), DW'(0));
      check_val("rst_tuser_a", DW'(out_user), DW'(0));

      // single-beat completion with known header
      hdr = {32'hDEAD_BEEF, 96'h0123_0045_ABCD_8010_0000_0001};
      send_beat(hdr, 16'hFFFF, 1'b1, 4'h0);
      check_val("latency_valid", DW'(out_valid), DW'(1'b1));
      check_val("lowaddr", DW'(out_data[6:0]), DW'(7'h45));
      check_val("req_id", DW'(out_data[63:48]), DW'(16'h0123));
      check_val("tag", DW'(out_data[71:64]), DW'(8'h00));
      check_val("cpl_id", DW'(out_data[87:72]), DW'(16'hABCD));
      check_val("byte_cnt", DW'(out_data[28:16]), DW'(13'h010));
      check_val("dw_cnt", DW'(out_data[42:32]), DW'(11'd1));
      check_val("payload0", DW'(out_data[127:96]), DW'(32'hDEAD_BEEF));
      check_val("tlast_a", DW'(out_last), DW'(1'b1));
      check_val("tkeep_a", DW'(out_keep), DW'(4'hF));
      idle(2);

      // three-beat completion back to back, then a header again
      for (int b = 0; b < 3; b++)
         send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, (b == 2), 4'h0);
      send_beat({$urandom, $urandom, $urandom, $urandom}, 16'h0FFF, 1'b1, 4'h0);
      drain();

      // backpressure: 4 buffered + 1 in the output register
      out_ready = 4'h0;
      acc_cnt   = 0;
      in_valid  = 1'b1;
      in_keep   = 16'hFFFF;
      in_user   = 4'h0;
      for (int c = 0; c < 8; c++) begin
         in_data = {4{32'h5A5A_0000 ^ 32'(acc_cnt)}};
         in_last = (acc_cnt == 4);
         step();
         if (acc_flag) acc_cnt++;
      end
      in_valid = 1'b0;
      check_val("bp_accepted", DW'(acc_cnt), DW'(5));
      check_val("bp_tready", DW'(in_ready), DW'(1'b0));
      drain();

      // ECRC request, locked-read type and discontinue
      hdr = {$urandom, $urandom, $urandom, $urandom};
      hdr[29:24] = 6'b001011;
      hdr[15]    = 1'b0;
      send_beat(hdr, 16'hFFFF, 1'b1, 4'b1001);
      check_val("force_ecrc", DW'(out_data[95]), DW'(1'b1));
      check_val("locked_rd", DW'(out_data[29]), DW'(1'b1));
      check_val("discontinue", DW'(out_user[0]), DW'(1'b1));
      idle(1);
      hdr[29:24] = 6'b001010;
      send_beat(hdr, 16'hFFFF, 1'b1, 4'b0000);
      check_val("no_ecrc", DW'(out_data[95]), DW'(1'b0));
      check_val("not_locked", DW'(out_data[29]), DW'(1'b0));
      check_val("no_disc", DW'(out_user[0]), DW'(1'b0));
      drain();

      // reset in the middle of a TLP
      send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0, 4'h0);
      idle(1);
      out_ready = 4'h0;
      send_beat({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0, 4'h0);
      do_reset();
      check_val("mid_rst_valid", DW'(out_valid), DW'(1'b0));
      check_val("mid_rst_ready", DW'(in_ready), DW'(1'b1));
      out_ready = 4'hF;
      hdr = {$urandom, $urandom, $urandom, $urandom};
      send_beat(hdr, 16'hFFFF, 1'b1, 4'h0);
      check_val("mid_rst_hdr", DW'(out_data[95:0]), DW'(cc_desc(hdr, 1'b0)));
      drain();

      // parity on output byte 0 (0x00 then 0x01)
      hdr = {$urandom, $urandom, $urandom, $urandom};
      hdr[70:64] = 7'h00;
      send_beat(hdr, 16'hFFFF, 1'b1, 4'h0);
      check_val("par_byte00", DW'(out_user[1]), DW'(PAR_EN));
      hdr[70:64] = 7'h01;
      send_beat(hdr, 16'hFFFF, 1'b1, 4'h0);
      check_val("par_byte01", DW'(out_user[1]), DW'(1'b0));
      drain();

      // randomized traffic with random hard-IP backpressure
      have = 1'b0;
      left = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (!have && ($urandom_range(3) != 0)) begin
            if (left == 0) left = int'($urandom_range(4, 1));
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_keep = ($urandom_range(3) == 0) ? 16'($urandom) : 16'hFFFF;
            in_user = 4'($urandom);
            left--;
            in_last = (left == 0);
            have    = 1'b1;
         end
         in_valid  = have;
         out_ready = ($urandom_range(3) != 0) ? (4'($urandom) | 4'h1) : (4'($urandom) & 4'hE);
         step();
         if (acc_flag) have = 1'b0;
      end
      drain();

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
